zero_cross_period: RTL and testbench

- Front-end conditioning stage for the sequence decomposer's phase-measurement path.
- Watches one signed sampled phase voltage and detects zero crossings cleanly, with hysteresis and a lockout window.
- Emits single-cycle rising and falling crossing strobes and measures the signal period, in samples, between consecutive falling crossings.
- The downstream phase-measurement stage uses the strobes as noise-free crossing references; the period normalises its phase count.

---
 rtl/zero_cross_period.sv | 111 +++++++++++
 tb/tb_zero_cross_period.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/zero_cross_period.sv
// zero_cross_period: hysteretic zero-crossing detector with lockout and fall-to-fall period measurement
//   clk, rst (async active-low)  | sample_en qualifies Vin (signed M-bit sample)
//   polarity: decided sign; rise_pulse/fall_pulse: one-cycle accepted crossing strobes
//   period/period_valid: samples between the last two falls; period_ovf: sticky counter saturation
//   Macro ZC_PERIOD_AVG_EN: period reports the mean of the last 4 measurements instead
module zero_cross_period #(
  parameter int M       = 14,
  parameter int HYST    = 64,
  parameter int CW      = 16,
  parameter int LOCKOUT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_en,
  input  logic signed [M-1:0] Vin,
  output logic                polarity,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic [CW-1:0]       period,
  output logic                period_valid,
  output logic                period_ovf
);
  localparam int LW = $clog2(LOCKOUT + 1);
  localparam logic signed [M-1:0] HI_T = M'(HYST);
  localparam logic signed [M-1:0] LO_T = -HI_T;
  localparam logic [CW-1:0] MAX = '1;
  localparam logic [LW-1:0] LK = LW'(LOCKOUT);
  typedef enum logic [1:0] {INIT, POS, NEG} state_t;
  state_t state_q, state_d;
  logic [LW-1:0] lock_q, lock_d;
  logic [CW-1:0] per_q, per_d, period_q, period_d, meas;
  logic armed_q, armed_d, ovf_q, ovf_d, polarity_q, rise_q, fall_q, valid_q, valid_d;
  logic hi, lo, open, rise, fall, take;
`ifdef ZC_PERIOD_AVG_EN
  logic [CW-1:0] h0_q, h0_d, h1_q, h1_d, h2_q, h2_d;
  logic [1:0] cnt_q, cnt_d;
  logic [CW+1:0] sum;
`endif
  always_comb begin
    hi = Vin > HI_T;
    lo = Vin < LO_T;
    open = lock_q >= LK;
    rise = sample_en && state_q == NEG && hi && open;
    fall = sample_en && state_q == POS && lo && open;
    // the crossing sample itself is the first sample of the new period
    meas = (per_q == MAX) ? MAX : per_q + 1'b1;
    state_d = !sample_en ? state_q : rise ? POS : fall ? NEG :
              (state_q == INIT && hi) ? POS : (state_q == INIT && lo) ? NEG : state_q;
    lock_d = !sample_en ? lock_q : (rise || fall) ? '0 : (lock_q == LK) ? lock_q : lock_q + 1'b1;
    per_d = !sample_en ? per_q : fall ? '0 : meas;
    armed_d = armed_q | fall;
    ovf_d = ovf_q | (sample_en && per_q == MAX);
    take = fall && armed_q;
`ifdef ZC_PERIOD_AVG_EN
    h0_d = take ? meas : h0_q;
    h1_d = take ? h0_q : h1_q;
    h2_d = take ? h1_q : h2_q;
    cnt_d = (take && cnt_q != 2'd3) ? cnt_q + 2'd1 : cnt_q;
    sum = {2'b0, meas} + {2'b0, h0_q} + {2'b0, h1_q} + {2'b0, h2_q};
    // window is full only once three earlier measurements are held
    valid_d = take && cnt_q == 2'd3;
    period_d = valid_d ? sum[CW+1:2] : period_q;
`else
    valid_d = take;
    period_d = take ? meas : period_q;
`endif
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= INIT;
      lock_q     <= '0;
      per_q      <= '0;
      period_q   <= '0;
      armed_q    <= 1'b0;
      ovf_q      <= 1'b0;
      polarity_q <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      valid_q    <= 1'b0;
`ifdef ZC_PERIOD_AVG_EN
      h0_q  <= '0;
      h1_q  <= '0;
      h2_q  <= '0;
      cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      lock_q     <= lock_d;
      per_q      <= per_d;
      period_q   <= period_d;
      armed_q    <= armed_d;
      ovf_q      <= ovf_d;
      polarity_q <= state_d == POS;
      rise_q     <= rise;
      fall_q     <= fall;
      valid_q    <= valid_d;
`ifdef ZC_PERIOD_AVG_EN
      h0_q  <= h0_d;
      h1_q  <= h1_d;
      h2_q  <= h2_d;
      cnt_q <= cnt_d;
`endif
    end
  end
  assign polarity     = polarity_q;
  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign period       = period_q;
  assign period_valid = valid_q;
  assign period_ovf   = ovf_q;
endmodule

// File: tb/tb_zero_cross_period.sv
// tb_zero_cross_period: directed scoreboard bench for zero_cross_period (default build and ZC_PERIOD_AVG_EN)
`timescale 1ns/1ps
module tb_zero_cross_period;
  localparam int R = 1, F = 2;
  logic clk = 0, rst = 0, sample_en = 0;
  logic signed [13:0] Vin = '0;
  logic polarity, rise_pulse, fall_pulse, period_valid, period_ovf;
  logic [15:0] period;
  logic pol6, rise6, fall6, valid6, ovf6;
  logic [5:0] per6;
  typedef struct {logic rise; logic valid; logic [15:0] per;} exp_t;
  exp_t q[$];
  exp_t em;
  int checks = 0, errors = 0;
  int n = 0, armed = 0, last_per = 0, last_meas = 0, gap = 0, cyc = 0;
  int fall_prev = 0, fall_last = 0, exp6 = 0;
  int hist[$];
  int noise[8] = '{50, -50, 64, -64, 63, -63, 0, -50};

  zero_cross_period dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .Vin(Vin), .polarity(polarity),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .period(period),
    .period_valid(period_valid), .period_ovf(period_ovf));

  zero_cross_period #(.CW(6)) u6 (
    .clk(clk), .rst(rst), .sample_en(sample_en), .Vin(Vin), .polarity(pol6),
    .rise_pulse(rise6), .fall_pulse(fall6), .period(per6),
    .period_valid(valid6), .period_ovf(ovf6));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int avg_sat(input int mx);
    int s = 0;
    foreach (hist[i]) s += (hist[i] > mx) ? mx : hist[i];
    return s / 4;
  endfunction

  task automatic push_fall();
    exp_t e;
    int m = n;
    n = 0;
    last_meas = m;
    e.rise = 0;
    e.valid = 0;
    if (armed != 0) begin
`ifdef ZC_PERIOD_AVG_EN
      hist.push_back(m);
      if (hist.size() > 4) void'(hist.pop_front());
      if (hist.size() == 4) begin
        e.valid = 1;
        last_per = avg_sat(65535);
      end
`else
      e.valid = 1;
      last_per = (m > 65535) ? 65535 : m;
`endif
    end
    e.per = 16'(last_per);
    armed = 1;
    q.push_back(e);
  endtask

  task automatic drive(input int v, input int ev);
    if (gap != 0) begin
      sample_en = 0;
      Vin = -Vin;
      @(posedge clk); #1;
    end
    Vin = 14'(v);
    sample_en = 1;
    n++;
    if (ev == R) q.push_back('{1'b1, 1'b0, 16'(last_per)});
    if (ev == F) push_fall();
    @(posedge clk); #1;
    sample_en = 0;
  endtask

  task automatic phase(input int v, input int ev, input int len, input bit g);
    int sgn = (v > 0) ? 1 : -1;
    drive(v, ev);
    for (int i = 1; i < len; i++)
      drive(!g ? v : (i <= 7) ? ((i % 2 != 0) ? -sgn * 100 : sgn * 100) : noise[(i - 8) % 8], 0);
  endtask

  always @(negedge clk) begin
    if (rst && (rise_pulse || fall_pulse)) begin
      if (q.size() == 0) chk("unexpected_pulse", {30'b0, rise_pulse, fall_pulse}, 0);
      else begin
        em = q.pop_front();
        chk("pulse_kind", {30'b0, rise_pulse, fall_pulse}, em.rise ? 2 : 1);
        chk("period_valid", period_valid, em.valid);
        chk("period", period, em.per);
        if (fall_pulse) begin
          fall_prev = fall_last;
          fall_last = cyc;
        end
      end
    end
    if (period_valid) chk("valid_with_fall", fall_pulse, 1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_polarity", polarity, 0);
    chk("rst_rise", rise_pulse, 0);
    chk("rst_fall", fall_pulse, 0);
    chk("rst_period", period, 0);
    chk("rst_valid", period_valid, 0);
    chk("rst_ovf", period_ovf, 0);
    rst = 1;
    for (int i = 0; i < 20; i++) drive(30, 0);
    chk("init_polarity", polarity, 0);
    chk("init_period", period, 0);
    for (int i = 0; i < 16; i++) drive(1000, 0);
    chk("init_to_pos", polarity, 1);
    for (int k = 0; k < 5; k++) begin
      phase(-1000, F, 16, 0);
      chk("neg_polarity", polarity, 0);
      phase(1000, R, 16, 0);
    end
    for (int k = 0; k < 2; k++) begin
      phase(-1000, F, 16, 1);
      phase(1000, R, 16, 1);
    end
    gap = 1;
    for (int k = 0; k < 2; k++) begin
      phase(-1000, F, 16, 0);
      phase(1000, R, 16, 0);
    end
    gap = 0;
    chk("fall_spacing_clk", fall_last - fall_prev, 64);
    phase(-1000, F, 16, 0);
    drive(1000, R);
    for (int i = 0; i < 8; i++) drive(-1000, 0);
    drive(-1000, F);
    for (int i = 0; i < 15; i++) drive(-1000, 0);
    phase(1000, R, 16, 0);
    chk("pre_ovf6", ovf6, 0);
    for (int i = 0; i < 100; i++) drive(1000, 0);
    drive(-1000, F);
`ifdef ZC_PERIOD_AVG_EN
    exp6 = avg_sat(63);
`else
    exp6 = (last_meas > 63) ? 63 : last_meas;
`endif
    chk("ovf6_fall", fall6, 1);
    chk("ovf6_valid", valid6, 1);
    chk("ovf6_period", per6, exp6);
    chk("ovf6_flag", ovf6, 1);
    chk("main_no_ovf", period_ovf, 0);
    phase(-1000, 0, 15, 0);
    phase(1000, R, 16, 0);
    phase(-1000, F, 16, 0);
    chk("ovf6_sticky", ovf6, 1);
    for (int i = 0; i < 5; i++) drive(-1000, 0);
    chk("queue_before_rst", q.size(), 0);
    #3 rst = 0;
    #1;
    chk("mid_rst_polarity", polarity, 0);
    chk("mid_rst_period", period, 0);
    chk("mid_rst_valid", period_valid, 0);
    chk("mid_rst_ovf6", ovf6, 0);
    armed = 0; n = 0; last_per = 0; hist.delete();
    @(posedge clk); #1;
    rst = 1;
    for (int i = 0; i < 16; i++) drive(1000, 0);
    phase(-1000, F, 15, 0);
    phase(1000, R, 15, 0);
    phase(-1000, F, 17, 0);
    phase(1000, R, 17, 0);
    phase(-1000, F, 16, 0);
    phase(1000, R, 16, 0);
    phase(-1000, F, 18, 0);
    phase(1000, R, 18, 0);
    drive(-1000, F);
`ifdef ZC_PERIOD_AVG_EN
    chk("avg_final", period, 33);
`else
    chk("raw_final", period, 36);
`endif
    chk("final_valid", period_valid, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
